// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI config-space arbiter.
// Consumers: pci_cfg_arb (top) and pci_cfg_rr_arb (round-robin picker).
package pci_pkg;

    localparam int unsigned CFG_OFFSET_W        = 6;
    localparam int unsigned CFG_DATA_W          = 32;
    localparam int unsigned CFG_BE_W            = 4;
    localparam int unsigned CFG_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } cfg_state_t;

    // One latched config-space access as presented on the cfg_* port.
    typedef struct packed {
        logic                    iswrite;
        logic [CFG_OFFSET_W-1:0] offset;
        logic [CFG_DATA_W-1:0]   write_val;
        logic [CFG_BE_W-1:0]     be;
    } cfg_acc_t;

endpackage

// File: rtl/pci_cfg_rr_arb.sv
// Two-way round-robin picker: a lone request wins, on a tie the last winner loses.
module pci_cfg_rr_arb
    import pci_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant_c
);

    always_comb begin
        o_grant_c = 2'b00;
        case (i_req)
            2'b01:   o_grant_c = 2'b01;
            2'b10:   o_grant_c = 2'b10;
            2'b11:   o_grant_c = i_last ? 2'b01 : 2'b10;
            default: o_grant_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/pci_cfg_arb.sv
// Arbitrates two requesters onto one config-space access port (IDLE/ACTIVE/DONE).
// Optional watchdog abort is built when PCI_CFG_ARB_TIMEOUT_EN is defined.
module pci_cfg_arb
    import pci_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = CFG_TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    r0_req,
    input  logic                    r0_iswrite,
    input  logic [CFG_OFFSET_W-1:0] r0_offset,
    input  logic [CFG_DATA_W-1:0]   r0_write_val,
    input  logic [CFG_BE_W-1:0]     r0_be,
    output logic [CFG_DATA_W-1:0]   r0_read_val,
    output logic                    r0_done,
    output logic                    r0_w_err,

    input  logic                    r1_req,
    input  logic                    r1_iswrite,
    input  logic [CFG_OFFSET_W-1:0] r1_offset,
    input  logic [CFG_DATA_W-1:0]   r1_write_val,
    input  logic [CFG_BE_W-1:0]     r1_be,
    output logic [CFG_DATA_W-1:0]   r1_read_val,
    output logic                    r1_done,
    output logic                    r1_w_err,

    output logic                    cfg_enable,
    output logic                    cfg_iswrite,
    output logic [CFG_OFFSET_W-1:0] cfg_offset,
    output logic [CFG_DATA_W-1:0]   cfg_write_val,
    output logic [CFG_BE_W-1:0]     cfg_be,
    input  logic [CFG_DATA_W-1:0]   cfg_read_val,
    input  logic                    cfg_done,
    input  logic                    cfg_w_err,

    output logic [1:0]              grant,
    output logic                    timeout
);

    cfg_state_t              r_state;
    cfg_acc_t                r_acc;
    logic                    r_cfg_enable;
    logic [1:0]              r_grant;
    logic                    r_owner;
    logic                    r_last;
    logic [CFG_DATA_W-1:0]   r_r0_read_val;
    logic [CFG_DATA_W-1:0]   r_r1_read_val;
    logic                    r_r0_done;
    logic                    r_r1_done;
    logic                    r_r0_w_err;
    logic                    r_r1_w_err;

    logic [1:0]              w_grant_c;
    cfg_acc_t                w_sel_acc;
    logic                    w_cfg_hit;
    logic                    w_to_hit;
    logic                    w_fin;
    logic [CFG_DATA_W-1:0]   w_fin_val;
    logic                    w_fin_err;

    pci_cfg_rr_arb u_rr_arb (
        .i_req     ({r1_req, r0_req}),
        .i_last    (r_last),
        .o_grant_c (w_grant_c)
    );

    assign w_sel_acc = w_grant_c[1] ? cfg_acc_t'{r1_iswrite, r1_offset, r1_write_val, r1_be}
                                    : cfg_acc_t'{r0_iswrite, r0_offset, r0_write_val, r0_be};

    // A watchdog abort completes like a normal access but with all-ones data and an error.
    assign w_cfg_hit = (r_state == ST_ACTIVE) && cfg_done;
    assign w_fin     = w_cfg_hit || w_to_hit;
    assign w_fin_val = w_to_hit ? {CFG_DATA_W{1'b1}} : cfg_read_val;
    assign w_fin_err = w_to_hit || cfg_w_err;

`ifdef PCI_CFG_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_timeout;

    // cfg_done on the limit cycle wins over the abort.
    assign w_to_hit = (r_state == ST_ACTIVE) && !cfg_done
                      && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_hit;
            if (r_state == ST_ACTIVE) begin
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = ^(32'(TIMEOUT_CYCLES));
    assign w_to_hit             = 1'b0;
    assign timeout              = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_acc         <= '0;
            r_cfg_enable  <= 1'b0;
            r_grant       <= 2'b00;
            r_owner       <= 1'b0;
            r_last        <= 1'b1;
            r_r0_read_val <= '0;
            r_r1_read_val <= '0;
            r_r0_done     <= 1'b0;
            r_r1_done     <= 1'b0;
            r_r0_w_err    <= 1'b0;
            r_r1_w_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant_c) begin
                        r_acc        <= w_sel_acc;
                        r_cfg_enable <= 1'b1;
                        r_grant      <= w_grant_c;
                        r_owner      <= w_grant_c[1];
                        r_last       <= w_grant_c[1];
                        r_state      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_fin) begin
                        r_cfg_enable <= 1'b0;
                        r_state      <= ST_DONE;
                        if (r_owner) begin
                            r_r1_read_val <= w_fin_val;
                            r_r1_w_err    <= w_fin_err;
                            r_r1_done     <= 1'b1;
                        end else begin
                            r_r0_read_val <= w_fin_val;
                            r_r0_w_err    <= w_fin_err;
                            r_r0_done     <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_r0_done <= 1'b0;
                    r_r1_done <= 1'b0;
                    r_grant   <= 2'b00;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cfg_enable    = r_cfg_enable;
    assign cfg_iswrite   = r_acc.iswrite;
    assign cfg_offset    = r_acc.offset;
    assign cfg_write_val = r_acc.write_val;
    assign cfg_be        = r_acc.be;
    assign grant         = r_grant;
    assign r0_read_val   = r_r0_read_val;
    assign r1_read_val   = r_r1_read_val;
    assign r0_done       = r_r0_done;
    assign r1_done       = r_r1_done;
    assign r0_w_err      = r_r0_w_err;
    assign r1_w_err      = r_r1_w_err;

endmodule

// File: tb/tb_pci_cfg_arb.sv
// Self-checking bench for pci_cfg_arb: transaction-level reference model, directed and random stimulus.
// Timeout scenarios run only when PCI_CFG_ARB_TIMEOUT_EN is defined.
module tb_pci_cfg_arb;

`ifdef PCI_CFG_ARB_TIMEOUT_EN
    localparam int unsigned TO    = 4;
    localparam bit          TO_EN = 1'b1;
`else
    localparam int unsigned TO    = 16;
    localparam bit          TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_iswrite, r1_req, r1_iswrite;
    logic [5:0]  r0_offset, r1_offset;
    logic [31:0] r0_write_val, r1_write_val;
    logic [3:0]  r0_be, r1_be;
    logic [31:0] r0_read_val, r1_read_val;
    logic        r0_done, r1_done, r0_w_err, r1_w_err;
    logic        cfg_enable, cfg_iswrite;
    logic [5:0]  cfg_offset;
    logic [31:0] cfg_write_val;
    logic [3:0]  cfg_be;
    logic [31:0] cfg_read_val;
    logic        cfg_done, cfg_w_err;
    logic [1:0]  grant;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;
    bit auto_mode = 1'b0;

    pci_cfg_arb #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_iswrite(r0_iswrite), .r0_offset(r0_offset),
        .r0_write_val(r0_write_val), .r0_be(r0_be), .r0_read_val(r0_read_val),
        .r0_done(r0_done), .r0_w_err(r0_w_err),
        .r1_req(r1_req), .r1_iswrite(r1_iswrite), .r1_offset(r1_offset),
        .r1_write_val(r1_write_val), .r1_be(r1_be), .r1_read_val(r1_read_val),
        .r1_done(r1_done), .r1_w_err(r1_w_err),
        .cfg_enable(cfg_enable), .cfg_iswrite(cfg_iswrite), .cfg_offset(cfg_offset),
        .cfg_write_val(cfg_write_val), .cfg_be(cfg_be), .cfg_read_val(cfg_read_val),
        .cfg_done(cfg_done), .cfg_w_err(cfg_w_err),
        .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: one access in flight, tracked by owner, snapshot and ACTIVE age.
    bit          m_busy, m_wrap, m_abort;
    int          m_age, m_last, m_owner;
    logic        e_en, e_isw, e_to;
    logic [5:0]  e_off;
    logic [31:0] e_wv;
    logic [3:0]  e_be;
    logic [1:0]  e_grant;
    logic [31:0] e_rv   [2];
    logic        e_done [2];
    logic        e_werr [2];

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_busy = 1'b0; m_wrap = 1'b0; m_age = 0; m_last = 1; m_owner = 0;
                e_en = 1'b0; e_isw = 1'b0; e_off = '0; e_wv = '0; e_be = '0;
                e_grant = 2'b00; e_to = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    e_rv[i] = '0; e_done[i] = 1'b0; e_werr[i] = 1'b0;
                end
            end else if (m_wrap) begin
                m_wrap = 1'b0; m_busy = 1'b0; e_grant = 2'b00; e_to = 1'b0;
                e_done[0] = 1'b0; e_done[1] = 1'b0;
            end else if (m_busy) begin
                m_age++;
                if (cfg_done || (TO_EN && m_age >= int'(TO))) begin
                    m_abort = !cfg_done;
                    e_rv[m_owner]   = m_abort ? 32'hFFFF_FFFF : cfg_read_val;
                    e_werr[m_owner] = m_abort ? 1'b1 : cfg_w_err;
                    e_done[m_owner] = 1'b1;
                    e_to = m_abort; e_en = 1'b0; m_wrap = 1'b1;
                end
            end else if (r0_req || r1_req) begin
                m_owner = (r0_req && r1_req) ? 1 - m_last : (r1_req ? 1 : 0);
                m_last  = m_owner;
                if (m_owner == 1) begin
                    e_isw = r1_iswrite; e_off = r1_offset; e_wv = r1_write_val; e_be = r1_be;
                    e_grant = 2'b10;
                end else begin
                    e_isw = r0_iswrite; e_off = r0_offset; e_wv = r0_write_val; e_be = r0_be;
                    e_grant = 2'b01;
                end
                e_en = 1'b1; m_busy = 1'b1; m_age = 0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("cfg_enable", 32'(cfg_enable), 32'(e_en));
        if (e_en) begin
            check("cfg_iswrite", 32'(cfg_iswrite), 32'(e_isw));
            check("cfg_offset", 32'(cfg_offset), 32'(e_off));
            check("cfg_write_val", cfg_write_val, e_wv);
            check("cfg_be", 32'(cfg_be), 32'(e_be));
        end
        check("grant", 32'(grant), 32'(e_grant));
        check("timeout", 32'(timeout), 32'(e_to));
        check("r0_done", 32'(r0_done), 32'(e_done[0]));
        check("r1_done", 32'(r1_done), 32'(e_done[1]));
        check("r0_read_val", r0_read_val, e_rv[0]);
        check("r1_read_val", r1_read_val, e_rv[1]);
        check("r0_w_err", 32'(r0_w_err), 32'(e_werr[0]));
        check("r1_w_err", 32'(r1_w_err), 32'(e_werr[1]));
    endtask

    // One cycle: compare at the falling edge, then apply requester/responder behaviour.
    task automatic tick();
        bit d0, d1;
        @(negedge clk);
        compare_all();
        d0 = r0_done;
        d1 = r1_done;
        if (d0) r0_req = 1'b0;
        if (d1) r1_req = 1'b0;
        if (auto_mode) begin
            rst          = ($urandom_range(0, 599) != 0);
            r0_iswrite   = 1'($urandom_range(0, 1));
            r0_offset    = 6'($urandom);
            r0_write_val = $urandom;
            r0_be        = 4'($urandom);
            r1_iswrite   = 1'($urandom_range(0, 1));
            r1_offset    = 6'($urandom);
            r1_write_val = $urandom;
            r1_be        = 4'($urandom);
            if (!r0_req && !d0 && $urandom_range(0, 3) == 0) r0_req = 1'b1;
            if (!r1_req && !d1 && $urandom_range(0, 3) == 0) r1_req = 1'b1;
            cfg_done     = ($urandom_range(0, 99) < 35);
            cfg_read_val = $urandom;
            cfg_w_err    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_grant(input logic [1:0] exp, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (grant == 2'b00 && n < budget);
        check("wait_grant", 32'(grant), 32'(exp));
    endtask

    task automatic wait_done(input logic [1:0] exp, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(r0_done || r1_done) && n < budget);
        check("wait_done", 32'({r1_done, r0_done}), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        r0_req = 1'b0; r0_iswrite = 1'b0; r0_offset = '0; r0_write_val = '0; r0_be = '0;
        r1_req = 1'b0; r1_iswrite = 1'b0; r1_offset = '0; r1_write_val = '0; r1_be = '0;
        cfg_read_val = '0; cfg_done = 1'b0; cfg_w_err = 1'b0;
        repeat (2) @(posedge clk);
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_cfg_enable", 32'(cfg_enable), 32'h0);
        check("rst_r0_read_val", r0_read_val, 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rst = 1'b1;

        // Single r0 read completing on the first ACTIVE cycle.
        r0_req = 1'b1; r0_iswrite = 1'b0; r0_offset = 6'h00; r0_be = 4'hF;
        wait_grant(2'b01, 4);
        check("rd_cfg_offset", 32'(cfg_offset), 32'h0);
        check("rd_cfg_iswrite", 32'(cfg_iswrite), 32'h0);
        cfg_done = 1'b1; cfg_read_val = 32'h1234_5678;
        tick();
        cfg_done = 1'b0;
        check("rd_r0_done", 32'(r0_done), 32'h1);
        check("rd_r0_read_val", r0_read_val, 32'h1234_5678);
        check("rd_r1_done", 32'(r1_done), 32'h0);
        check("rd_r1_read_val", r1_read_val, 32'h0);
        tick();
        check("rd_r0_done_drop", 32'(r0_done), 32'h0);

        // Ties after reset: r0 first, then r1; later ties alternate.
        do_reset();
        cfg_done = 1'b1; cfg_read_val = 32'h0000_0035;
        r0_req = 1'b1; r1_req = 1'b1;
        wait_grant(2'b01, 4);
        wait_done(2'b01, 4);
        wait_grant(2'b10, 6);
        wait_done(2'b10, 4);
        r0_req = 1'b1;
        wait_grant(2'b01, 6);
        wait_done(2'b01, 4);
        r0_req = 1'b1; r1_req = 1'b1;
        wait_grant(2'b10, 6);
        wait_done(2'b10, 4);
        wait_grant(2'b01, 6);
        wait_done(2'b01, 4);
        cfg_done = 1'b0;

        // r1 write: fields stay latched while requester inputs change.
        tick();
        r1_req = 1'b1; r1_iswrite = 1'b1; r1_offset = 6'h01; r1_be = 4'b0011;
        r1_write_val = 32'hCAFE_0001;
        wait_grant(2'b10, 6);
        r1_be = 4'b1100; r1_offset = 6'h3F; r1_write_val = 32'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wr_cfg_be", 32'(cfg_be), 32'h3);
            check("wr_cfg_offset", 32'(cfg_offset), 32'h1);
            check("wr_cfg_enable", 32'(cfg_enable), 32'h1);
        end
        check("wr_cfg_write_val", cfg_write_val, 32'hCAFE_0001);
        cfg_done = 1'b1; cfg_w_err = 1'b1; cfg_read_val = 32'h0;
        wait_done(2'b10, 4);
        check("wr_r1_w_err", 32'(r1_w_err), 32'h1);
        cfg_done = 1'b0; cfg_w_err = 1'b0;
        tick();

        // Reset in the middle of an access aborts it without completion.
        r0_req = 1'b1; r0_iswrite = 1'b0; r0_offset = 6'h05;
        wait_grant(2'b01, 6);
        tick();
        rst = 1'b0; r0_req = 1'b0; r1_req = 1'b1;
        tick();
        check("mid_rst_cfg_enable", 32'(cfg_enable), 32'h0);
        check("mid_rst_r0_done", 32'(r0_done), 32'h0);
        check("mid_rst_grant", 32'(grant), 32'h0);
        rst = 1'b1;
        wait_grant(2'b10, 4);
        cfg_done = 1'b1; cfg_read_val = 32'h0BAD_F00D;
        wait_done(2'b10, 4);
        check("post_rst_r1_read_val", r1_read_val, 32'h0BAD_F00D);
        check("post_rst_r0_read_val", r0_read_val, 32'h0);
        cfg_done = 1'b0;
        tick();

`ifdef PCI_CFG_ARB_TIMEOUT_EN
        // Watchdog abort after TO ACTIVE cycles, then a completion exactly on the limit cycle.
        begin
            int n_act;
            r0_req = 1'b1;
            wait_grant(2'b01, 6);
            n_act = 1;
            for (int k = 0; k < 20 && !r0_done; k++) begin
                tick();
                if (cfg_enable) n_act++;
            end
            check("to_active_cycles", 32'(n_act), 32'd4);
            check("to_timeout", 32'(timeout), 32'h1);
            check("to_r0_read_val", r0_read_val, 32'hFFFF_FFFF);
            check("to_r0_w_err", 32'(r0_w_err), 32'h1);
            tick();
            r0_req = 1'b1;
            wait_grant(2'b01, 6);
            tick();
            tick();
            tick();
            cfg_done = 1'b1; cfg_read_val = 32'hABCD_0039; cfg_w_err = 1'b0;
            wait_done(2'b01, 2);
            check("lim_timeout", 32'(timeout), 32'h0);
            check("lim_r0_read_val", r0_read_val, 32'hABCD_0039);
            cfg_done = 1'b0;
            tick();
        end
`endif

        // Random traffic with occasional resets, checked every cycle against the model.
        auto_mode = 1'b1;
        for (int k = 0; k < 3000; k++) tick();
        auto_mode = 1'b0;
        rst = 1'b1; cfg_done = 1'b1;
        for (int k = 0; k < 20; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
